// File: rtl/delivery_pkg.sv
// Shared types and constants for the delivery round scheduler.
package delivery_pkg;

   localparam int unsigned LVL_W = 2;

   // BCD tens-digit thresholds for the distance-to-speed map
   localparam logic [3:0] BCD_TENS_FAR = 4'd3;
   localparam logic [3:0] BCD_TENS_MID = 4'd2;
   localparam logic [3:0] BCD_TENS_NEAR = 4'd1;

   typedef enum logic [3:0] {
      ST_INICIAL = 4'd0,
      ST_PREPARA = 4'd1,
      ST_MEDE    = 4'd2,
      ST_ESPERA  = 4'd3,
      ST_JOGA    = 4'd4,
      ST_FIM     = 4'd5
   } state_t;

   // Closer obstacle -> faster scroll; only hundreds and tens digits matter
   function automatic logic [LVL_W-1:0] map_level(input logic [3:0] hundreds,
                                                  input logic [3:0] tens);
      if (hundreds != 4'd0 || tens >= BCD_TENS_FAR) return 2'd0;
      else if (tens == BCD_TENS_MID)                return 2'd1;
      else if (tens == BCD_TENS_NEAR)               return 2'd2;
      else                                          return 2'd3;
   endfunction

endpackage

// File: rtl/delivery_tick_timer.sv
// Loadable down-counter: clear loads period-1, enable counts down and
// reloads automatically, done pulses on the last cycle of each period.
module delivery_tick_timer #(
   parameter int unsigned CW = 25
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [CW-1:0] period_i,
   input  logic          clear_i,
   input  logic          enable_i,
   output logic          done_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   assign done_o = enable_i && (cnt_q == '0);

   // next count: load on clear, otherwise count down and wrap to the period
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = period_i - CW'(1);
      end else if (enable_i) begin
         cnt_d = (cnt_q == '0) ? (period_i - CW'(1)) : (cnt_q - CW'(1));
      end
   end

   // counter register
   always_ff @(posedge clock) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/delivery_round_scheduler.sv
// Round sequencer for the delivery game: scroll ticks, periodic distance
// measurements with timeout, and distance-driven scroll speed.
module delivery_round_scheduler
   import delivery_pkg::*;
#(
   parameter int unsigned TICK_BASE     = 25_000_000,
   parameter int unsigned TICK_STEP     = 5_000_000,
   parameter int unsigned MEASURE_EVERY = 4,
   parameter int unsigned TIMEOUT       = 1_500_000,
   parameter int unsigned CW            = 25
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             jogar,
   input  logic             game_over,
   input  logic             velocity_ready,
   input  logic [11:0]      medida,
   output logic             reset_out,
   output logic             count_map,
   output logic             get_velocity,
   output logic             pronto,
   output logic             meas_timeout,
   output logic [LVL_W-1:0] speed_level,
   output logic [3:0]       estado
);

   if (TICK_BASE <= 3 * TICK_STEP) begin : g_bad_tick_params
      $error("delivery_round_scheduler: TICK_BASE must exceed 3*TICK_STEP");
   end
   if (MEASURE_EVERY < 1 || TIMEOUT < 1) begin : g_bad_count_params
      $error("delivery_round_scheduler: MEASURE_EVERY and TIMEOUT must be >= 1");
   end

   localparam int unsigned SCW = (MEASURE_EVERY > 1) ? $clog2(MEASURE_EVERY) : 1;
   localparam logic [CW-1:0] BASE_C    = CW'(TICK_BASE);
   localparam logic [CW-1:0] STEP_C    = CW'(TICK_STEP);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
   localparam logic [SCW-1:0] LAST_SCROLL = SCW'(MEASURE_EVERY - 1);

   state_t           state_q, state_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [SCW-1:0]   scroll_q, scroll_d;
   logic             count_map_q, count_map_d;
   logic             get_velocity_q, get_velocity_d;
   logic             meas_timeout_q, meas_timeout_d;
   logic [CW-1:0]    scroll_period;
   logic             tick_done, wait_done;
   logic             unused_units;

   // units digit never affects the speed level
   assign unused_units = ^medida[3:0];

   // Period is taken from the next level so the timer loads the freshly
   // measured speed on the same edge that enters JOGA.
   assign scroll_period = BASE_C - (STEP_C * CW'(level_d));

   delivery_tick_timer #(.CW(CW)) u_scroll_timer (
      .clock    (clock),
      .reset    (reset),
      .period_i (scroll_period),
      .clear_i  (state_q != ST_JOGA),
      .enable_i (state_q == ST_JOGA),
      .done_o   (tick_done)
   );

   delivery_tick_timer #(.CW(CW)) u_wait_timer (
      .clock    (clock),
      .reset    (reset),
      .period_i (TIMEOUT_C),
      .clear_i  (state_q != ST_ESPERA),
      .enable_i (state_q == ST_ESPERA),
      .done_o   (wait_done)
   );

   // speed level: cleared at round start, updated by a valid measurement
   always_comb begin
      level_d = level_q;
      if (state_q == ST_PREPARA) begin
         level_d = '0;
      end else if (state_q == ST_ESPERA && velocity_ready && !game_over) begin
         level_d = map_level(medida[11:8], medida[7:4]);
      end
   end

   // next state and pulse decisions; game_over outranks tick and measurement
   always_comb begin
      state_d        = state_q;
      scroll_d       = scroll_q;
      count_map_d    = 1'b0;
      meas_timeout_d = 1'b0;
      case (state_q)
         ST_INICIAL: if (jogar) state_d = ST_PREPARA;
         ST_PREPARA: begin
            scroll_d = '0;
            state_d  = ST_MEDE;
         end
         ST_MEDE: state_d = game_over ? ST_FIM : ST_ESPERA;
         ST_ESPERA: begin
            if (game_over) begin
               state_d = ST_FIM;
            end else if (velocity_ready) begin
               state_d = ST_JOGA;
            end else if (wait_done) begin
               meas_timeout_d = 1'b1;
               state_d        = ST_JOGA;
            end
         end
         ST_JOGA: begin
            if (game_over) begin
               state_d = ST_FIM;
            end else if (tick_done) begin
               count_map_d = 1'b1;
               if (scroll_q == LAST_SCROLL) begin
                  scroll_d = '0;
                  state_d  = ST_MEDE;
               end else begin
                  scroll_d = scroll_q + SCW'(1);
               end
            end
         end
         ST_FIM: if (jogar) state_d = ST_PREPARA;
         default: state_d = ST_INICIAL;
      endcase
      // MEDE lasts exactly one cycle, so the request pulses on entry
      get_velocity_d = (state_d == ST_MEDE);
   end

   // state, level, scroll count and registered pulses
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q        <= ST_INICIAL;
         level_q        <= '0;
         scroll_q       <= '0;
         count_map_q    <= 1'b0;
         get_velocity_q <= 1'b0;
         meas_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         level_q        <= level_d;
         scroll_q       <= scroll_d;
         count_map_q    <= count_map_d;
         get_velocity_q <= get_velocity_d;
         meas_timeout_q <= meas_timeout_d;
      end
   end

   assign reset_out    = (state_q == ST_PREPARA);
   assign pronto       = (state_q == ST_FIM);
   assign estado       = state_q;
   assign speed_level  = level_q;
   assign count_map    = count_map_q;
   assign get_velocity = get_velocity_q;
   assign meas_timeout = meas_timeout_q;

endmodule

// File: tb/tb_delivery_round_scheduler.sv
// Directed bench for delivery_round_scheduler with short periods.
module tb_delivery_round_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        jogar;
   logic        game_over;
   logic        velocity_ready;
   logic [11:0] medida;
   logic        reset_out;
   logic        count_map;
   logic        get_velocity;
   logic        pronto;
   logic        meas_timeout;
   logic [1:0]  speed_level;
   logic [3:0]  estado;

   int checks = 0;
   int errors = 0;

   // level-map vectors: distance, expected level, expected period
   logic [11:0] map_med [4] = '{12'h120, 12'h004, 12'h029, 12'h030};
   logic [1:0]  map_lvl [4] = '{2'd0, 2'd3, 2'd1, 2'd0};
   int          map_per [4] = '{40, 10, 30, 40};

   delivery_round_scheduler #(
      .TICK_BASE     (40),
      .TICK_STEP     (10),
      .MEASURE_EVERY (2),
      .TIMEOUT       (8),
      .CW            (25)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .jogar          (jogar),
      .game_over      (game_over),
      .velocity_ready (velocity_ready),
      .medida         (medida),
      .reset_out      (reset_out),
      .count_map      (count_map),
      .get_velocity   (get_velocity),
      .pronto         (pronto),
      .meas_timeout   (meas_timeout),
      .speed_level    (speed_level),
      .estado         (estado)
   );

   always #5 clock = ~clock;

   // {reset_out, count_map, get_velocity, pronto, meas_timeout, speed_level, estado}
   function automatic logic [10:0] outs();
      return {reset_out, count_map, get_velocity, pronto, meas_timeout, speed_level, estado};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // cycles until count_map is seen, -1 if the limit expires
   task automatic wait_cm(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (count_map === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_to(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (meas_timeout === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; jogar = 1'b0; game_over = 1'b0; velocity_ready = 1'b0; medida = '0;
      step(); step();
      checks++;
      if (outs() !== 11'b0_0_0_0_0_00_0000) begin
         errors++; $display("FAIL reset_state got %h exp %h", outs(), 11'h000);
      end
      reset = 1'b1; jogar = 1'b1;
      step();
      jogar = 1'b0;
      checks++;
      if (outs() !== 11'b1_0_0_0_0_00_0001) begin
         errors++; $display("FAIL prepara got %b exp %b", outs(), 11'b1_0_0_0_0_00_0001);
      end
      step();
      checks++;
      if (outs() !== 11'b0_0_1_0_0_00_0010) begin
         errors++; $display("FAIL mede_request got %b exp %b", outs(), 11'b0_0_1_0_0_00_0010);
      end
      step();
      checks++;
      if (outs() !== 11'b0_0_0_0_0_00_0011) begin
         errors++; $display("FAIL espera_entry got %b exp %b", outs(), 11'b0_0_0_0_0_00_0011);
      end
   endtask

   task automatic test_measure_ready();
      int n;
      velocity_ready = 1'b1; medida = 12'h015;
      step();
      velocity_ready = 1'b0;
      checks++;
      if (outs() !== 11'b0_0_0_0_0_10_0100) begin
         errors++; $display("FAIL ready_level got %b exp %b", outs(), 11'b0_0_0_0_0_10_0100);
      end
      wait_cm(100, n);
      checks++;
      if (n !== 20) begin errors++; $display("FAIL first_tick got %0d exp %0d", n, 20); end
      step();
      checks++;
      if (count_map !== 1'b0) begin errors++; $display("FAIL tick_width got %b exp %b", count_map, 1'b0); end
      // one cycle already consumed by the pulse-width check
      wait_cm(100, n);
      checks++;
      if (n !== 19) begin errors++; $display("FAIL second_tick got %0d exp %0d", n, 19); end
      checks++;
      if ({get_velocity, estado} !== 5'b1_0010) begin
         errors++; $display("FAIL remeasure got %b exp %b", {get_velocity, estado}, 5'b1_0010);
      end
      step();
      checks++;
      if ({get_velocity, estado} !== 5'b0_0011) begin
         errors++; $display("FAIL back_to_espera got %b exp %b", {get_velocity, estado}, 5'b0_0011);
      end
   endtask

   task automatic test_timeout();
      int n;
      wait_to(30, n);
      checks++;
      if (n !== 8) begin errors++; $display("FAIL timeout_delay got %0d exp %0d", n, 8); end
      checks++;
      if (outs() !== 11'b0_0_0_0_1_10_0100) begin
         errors++; $display("FAIL timeout_state got %b exp %b", outs(), 11'b0_0_0_0_1_10_0100);
      end
      wait_cm(100, n);
      checks++;
      if (n !== 20) begin errors++; $display("FAIL resume_tick got %0d exp %0d", n, 20); end
   endtask

   task automatic test_game_over_tick();
      repeat (19) step();
      checks++;
      if ({count_map, estado} !== 5'b0_0100) begin
         errors++; $display("FAIL pre_tick got %b exp %b", {count_map, estado}, 5'b0_0100);
      end
      game_over = 1'b1;
      step();
      game_over = 1'b0;
      checks++;
      if (outs() !== 11'b0_0_0_1_0_10_0101) begin
         errors++; $display("FAIL game_over_tick got %b exp %b", outs(), 11'b0_0_0_1_0_10_0101);
      end
      step();
      checks++;
      if (outs() !== 11'b0_0_0_1_0_10_0101) begin
         errors++; $display("FAIL fim_hold got %b exp %b", outs(), 11'b0_0_0_1_0_10_0101);
      end
      jogar = 1'b1;
      step();
      jogar = 1'b0;
      checks++;
      if (outs() !== 11'b1_0_0_0_0_10_0001) begin
         errors++; $display("FAIL new_round got %b exp %b", outs(), 11'b1_0_0_0_0_10_0001);
      end
      step();
      checks++;
      if (outs() !== 11'b0_0_1_0_0_00_0010) begin
         errors++; $display("FAIL new_round_level got %b exp %b", outs(), 11'b0_0_1_0_0_00_0010);
      end
      step();
   endtask

   task automatic test_level_map();
      int n;
      for (int i = 0; i < 4; i++) begin
         velocity_ready = 1'b1; medida = map_med[i];
         step();
         velocity_ready = 1'b0;
         checks++;
         if ({speed_level, estado} !== {map_lvl[i], 4'd4}) begin
            errors++; $display("FAIL map_level[%0d] got %b exp %b", i, {speed_level, estado}, {map_lvl[i], 4'd4});
         end
         wait_cm(100, n);
         checks++;
         if (n !== map_per[i]) begin errors++; $display("FAIL map_period[%0d] got %0d exp %0d", i, n, map_per[i]); end
         wait_cm(100, n);
         checks++;
         if (n !== map_per[i]) begin errors++; $display("FAIL map_period2[%0d] got %0d exp %0d", i, n, map_per[i]); end
         checks++;
         if ({get_velocity, estado} !== 5'b1_0010) begin
            errors++; $display("FAIL map_remeasure[%0d] got %b exp %b", i, {get_velocity, estado}, 5'b1_0010);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_espera();
      checks++;
      if (estado !== 4'd3) begin errors++; $display("FAIL mid_pre got %0d exp %0d", estado, 3); end
      reset = 1'b0;
      step();
      checks++;
      if (outs() !== 11'b0) begin errors++; $display("FAIL mid_reset got %b exp %b", outs(), 11'b0); end
      reset = 1'b1; velocity_ready = 1'b1; medida = 12'h004;
      step();
      velocity_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (outs() !== 11'b0) begin errors++; $display("FAIL late_ready[%0d] got %b exp %b", i, outs(), 11'b0); end
         step();
      end
   endtask

   initial begin
      test_reset();
      test_measure_ready();
      test_timeout();
      test_game_over_tick();
      test_level_map();
      test_reset_mid_espera();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
